// File: rtl/logic_op_pkg.sv
// logic_op_pkg: opcode encoding shared by the logic unit front end
package logic_op_pkg;
  localparam int OP_W = 2;
  typedef enum logic [OP_W-1:0] {OP_AND = 2'd0, OP_OR, OP_XOR, OP_NAND} op_t;
endpackage

// File: rtl/logic_op_eval.sv
// logic_op_eval: combinational bitwise evaluator, every opcode assigns y
module logic_op_eval
  import logic_op_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  op_t              op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] y
);
  always_comb begin
    unique case (op)
      OP_AND:  y = a & b;
      OP_OR:   y = a | b;
      OP_XOR:  y = a ^ b;
      OP_NAND: y = ~(a & b);
      default: y = '0;
    endcase
  end
endmodule

// File: rtl/logic_op_pipe.sv
// logic_op_pipe: valid/ready front end evaluating a bitwise op into a result FIFO
module logic_op_pipe
  import logic_op_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic [1:0]       out_op,
  output logic [15:0]      done_count
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
  logic [WIDTH-1:0] y;
  logic [WIDTH-1:0] res_q [DEPTH];
  logic [WIDTH-1:0] res_d [DEPTH];
  op_t              op_q  [DEPTH];
  op_t              op_d  [DEPTH];
  logic [AW-1:0]    head_q, head_d, tail_q, tail_d;
  logic [AW:0]      occ_q, occ_d;
  logic [15:0]      done_q, done_d;
  logic             live_q;
  logic             push, pop;
  logic_op_eval #(.WIDTH(WIDTH)) u_eval (.op(op_t'(op)), .a(a), .b(b), .y(y));
  // live_q holds off acceptance on the edge that releases reset
  assign in_ready   = live_q && (occ_q < FULL);
  assign out_valid  = occ_q != '0;
  assign push       = in_valid && in_ready;
  assign pop        = out_valid && out_ready;
  assign out_result = res_q[head_q];
  assign out_op     = op_q[head_q];
  assign done_count = done_q;
  always_comb begin
    res_d = res_q;
    op_d  = op_q;
    if (push) begin
      res_d[tail_q] = y;
      op_d[tail_q]  = op_t'(op);
    end
    tail_d = push ? tail_q + AW'(1) : tail_q;
    head_d = pop ? head_q + AW'(1) : head_q;
    occ_d  = occ_q + (AW+1)'(push) - (AW+1)'(pop);
    done_d = done_q + 16'(pop);
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      res_q  <= '{default: '0};
      op_q   <= '{default: OP_AND};
      head_q <= '0;
      tail_q <= '0;
      occ_q  <= '0;
      done_q <= '0;
      live_q <= 1'b0;
    end else begin
      res_q  <= res_d;
      op_q   <= op_d;
      head_q <= head_d;
      tail_q <= tail_d;
      occ_q  <= occ_d;
      done_q <= done_d;
      live_q <= 1'b1;
    end
  end
endmodule

// File: tb/tb_logic_op_pipe.sv
// tb_logic_op_pipe: directed table and handshake corner-case checks for logic_op_pipe
module tb_logic_op_pipe;
  logic        clk = 1'b0;
  logic        reset, in_valid, in_ready, out_valid, out_ready;
  logic [1:0]  op, out_op;
  logic [15:0] a, b, out_result, done_count;
  int          checks = 0;
  int          errors = 0;
  typedef struct {
    logic [1:0]  op;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] y;
  } vec_t;
  vec_t tv [10];
  logic_op_pipe #(.WIDTH(16), .DEPTH(2)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_op(out_op), .done_count(done_count)
  );
  always #5 clk = ~clk;
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", name, act, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic beat(input logic [1:0] o, input logic [15:0] x, input logic [15:0] z);
    in_valid = 1'b1;
    op = o;
    a = x;
    b = z;
  endtask
  initial begin
    tv[0] = '{2'd0, 16'h00F0, 16'h0FF0, 16'h00F0};
    tv[1] = '{2'd1, 16'h00F0, 16'h0FF0, 16'h0FF0};
    tv[2] = '{2'd2, 16'h00F0, 16'h0FF0, 16'h0F00};
    tv[3] = '{2'd3, 16'h00F0, 16'h0FF0, 16'hFF0F};
    tv[4] = '{2'd0, 16'hFFFF, 16'hFFFF, 16'hFFFF};
    tv[5] = '{2'd3, 16'hFFFF, 16'hFFFF, 16'h0000};
    tv[6] = '{2'd2, 16'hAAAA, 16'h5555, 16'hFFFF};
    tv[7] = '{2'd1, 16'h0000, 16'h0000, 16'h0000};
    tv[8] = '{2'd3, 16'h0000, 16'h1234, 16'hFFFF};
    tv[9] = '{2'd2, 16'h1234, 16'h1234, 16'h0000};
    reset = 1'b0;
    out_ready = 1'b0;
    beat(2'd1, 16'hDEAD, 16'hBEEF);
    repeat (3) tick();
    check("rst_out_valid", out_valid, 0);
    reset = 1'b1;
    tick();
    check("release_no_accept", out_valid, 0);
    check("rst_out_result", out_result, 0);
    check("rst_out_op", out_op, 0);
    check("rst_done", done_count, 0);
    check("rst_in_ready", in_ready, 1);
    in_valid = 1'b0;
    tick();
    check("still_empty", out_valid, 0);
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      beat(tv[i].op, tv[i].a, tv[i].b);
      tick();
      check($sformatf("vec%0d_valid", i), out_valid, 1);
      check($sformatf("vec%0d_result", i), out_result, tv[i].y);
      check($sformatf("vec%0d_op", i), out_op, tv[i].op);
    end
    in_valid = 1'b0;
    tick();
    check("vec_drain", out_valid, 0);
    check("vec_done", done_count, 10);
    out_ready = 1'b0;
    beat(2'd1, 16'h1111, 16'h2222);
    check("bp_ready0", in_ready, 1);
    tick();
    check("bp_first", out_result, 16'h3333);
    beat(2'd2, 16'hF0F0, 16'hFF00);
    tick();
    check("bp_full", in_ready, 0);
    check("bp_hold1", out_result, 16'h3333);
    beat(2'd0, 16'h1234, 16'h00FF);
    tick();
    check("bp_still_full", in_ready, 0);
    check("bp_hold2", out_result, 16'h3333);
    check("bp_hold_op", out_op, 1);
    out_ready = 1'b1;
    tick();
    check("bp_second", out_result, 16'h0FF0);
    check("bp_recover", in_ready, 1);
    tick();
    check("bp_third", out_result, 16'h0034);
    check("bp_third_op", out_op, 0);
    in_valid = 1'b0;
    tick();
    check("bp_empty", out_valid, 0);
    check("bp_done", done_count, 13);
    out_ready = 1'b0;
    beat(2'd1, 16'd0, 16'd0);
    tick();
    out_ready = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      beat(2'd1, 16'(k), 16'd0);
      tick();
      check($sformatf("pp%0d_result", k), out_result, k);
      check($sformatf("pp%0d_ready", k), in_ready, 1);
    end
    in_valid = 1'b0;
    tick();
    check("pp_empty", out_valid, 0);
    check("pp_done", done_count, 24);
    beat(2'd0, 16'h5A5A, 16'hFFFF);
    repeat (65511) @(posedge clk);
    #1;
    in_valid = 1'b0;
    tick();
    check("wrap_ffff", done_count, 16'hFFFF);
    beat(2'd0, 16'h0001, 16'h0001);
    tick();
    in_valid = 1'b0;
    check("wrap_pending", out_valid, 1);
    tick();
    check("wrap_zero", done_count, 16'h0000);
    out_ready = 1'b0;
    beat(2'd1, 16'h0F00, 16'h0000);
    tick();
    beat(2'd1, 16'h00F0, 16'h0000);
    tick();
    in_valid = 1'b0;
    check("mid_full", in_ready, 0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("mid_async_valid", out_valid, 0);
    check("mid_async_done", done_count, 0);
    @(negedge clk);
    reset = 1'b1;
    tick();
    check("mid_release_empty", out_valid, 0);
    beat(2'd2, 16'hABCD, 16'hFFFF);
    tick();
    in_valid = 1'b0;
    check("mid_first_valid", out_valid, 1);
    check("mid_first_result", out_result, 16'h5432);
    check("mid_first_op", out_op, 2);
    out_ready = 1'b1;
    tick();
    check("mid_single", out_valid, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/logic_op_pipe.md
# logic_op_pipe

Registered, flow-controlled front end for the 16-bit bitwise logic unit. It accepts an opcode and two operands over a valid/ready handshake and evaluates one of AND, OR, XOR or NAND, with every opcode covered so no latch is inferred. Results are buffered in a small FIFO and delivered downstream over a second valid/ready handshake. It sits between the operand source and the result consumer, and decouples them so a stalled consumer never drops or corrupts a result.

## Interface
Parameters:
- WIDTH, 16, operand/result width in bits.
- DEPTH, 2, result FIFO entries; power of two, ≥2.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset. Asserting it clears all state immediately; deassertion is synchronous to clk.
- in_valid  input  1  operand beat offered.
- in_ready  output  1  block can accept a beat this cycle.
- op  input  2  opcode: 0 AND, 1 OR, 2 XOR, 3 NAND.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- out_valid  output  1  result available.
- out_ready  input  1  consumer takes the result this cycle.
- out_result  output  WIDTH  head-of-FIFO result.
- out_op  output  2  opcode that produced out_result.
- done_count  output  16  number of results consumed; wraps modulo 2^16.

## Operation
- **Accept:** a beat is accepted on a rising clk edge with in_valid && in_ready. Result = f(op, a, b) is written at the FIFO tail together with op.
- **Evaluation:** purely bitwise, no carries, WIDTH bits in and WIDTH bits out. NAND = ~(a & b).
- **Input ready:** in_ready = (occupancy < DEPTH). It is registered-state-only and does not depend on out_ready.
- **Output handshake:**
  - Pop occurs on out_valid && out_ready.
  - out_valid = (occupancy ≠ 0).
  - out_result and out_op are driven from the head entry and held stable while out_valid && !out_ready.
- **Simultaneous push and pop:**
  - Allowed whenever in_ready = 1; occupancy is unchanged and both pointers advance.
  - When full, in_ready = 0, so a push cannot coincide with a pop in that cycle. The freed slot is visible the next cycle.
- **Counter:** done_count increments by 1 on each pop. 16'hFFFF + 1 → 16'h0000.
- **Pointers:** log2(DEPTH) bits each, wrap naturally. Occupancy is a separate log2(DEPTH)+1 bit counter.
- **Reset values:** in_ready = 1 once reset deasserts, out_valid = 0, out_result = 0, out_op = 0, done_count = 0, occupancy = 0.
- **Reset mid-operation:** all buffered results are discarded. A beat presented in the reset-release cycle is not accepted.
- **Inputs while in_ready = 0:** ignored; the source must hold the beat.
- **FIFO write rule:** no X or latch on any path. Every opcode writes the FIFO.

## Timing
- Latency: a beat accepted at edge N gives out_valid = 1 after edge N, i.e. the result is visible in cycle N+1 when the FIFO was empty. There is no combinational in→out path.
- Throughput: one result per cycle sustained when out_ready is held at 1.
- Backpressure: with out_ready = 0, exactly DEPTH beats are accepted, then in_ready falls after the edge that fills the FIFO.
- Recovery: the first pop from full raises in_ready in the following cycle.

## Structure
- Package logic_op_pkg:
  - op_t enum {OP_AND = 2'd0, OP_OR, OP_XOR, OP_NAND}.
  - Constant OP_W = 2.
- Sub-module logic_op_eval: combinational, parameter WIDTH, ports op, a, b, y. Uses a unique case with a default so every path assigns y.
- Top level contains: the evaluator instance, FIFO storage (result + op per entry), head/tail/occupancy registers and done_count.

## Test plan
- **Reset:** hold reset = 0 for 3 cycles with in_valid = 1 → out_valid = 0, in_ready = 1 after release, done_count = 0, and no entry written.
- **All opcodes:** a = 16'h00F0, b = 16'h0FF0, op = 0..3 on consecutive cycles with out_ready = 1 → out_result sequence 16'h00F0, 16'h0FF0, 16'h0F00, 16'hFF0F; out_op 0..3; each appears one cycle after its accept; done_count = 4.
- **Backpressure:** out_ready = 0, send 3 beats with in_valid held → only 2 accepted, in_ready = 0 from the third cycle, and out_result holds the first result unchanged. Raise out_ready → results appear in order, and the third beat is accepted the cycle after the first pop.
- **Simultaneous push/pop:** occupancy 1, in_valid = out_ready = 1 for 10 cycles → occupancy stays 1, 10 pops, results in input order.
- **Counter wrap:** preload via 65535 pops, then 1 more → done_count 16'hFFFF → 16'h0000.
- **Reset mid-stream:** FIFO full, pulse reset low for 1 cycle mid-cycle → out_valid drops asynchronously, and the next accepted beat is the first result seen.
